// File: rtl/mips_pkg.sv
// Shared definitions for the core's memory-side blocks: default widths,
// arbiter state encoding and the port indices used by the read-return tag.
package mips_pkg;

   localparam int ADDR_W = 10;
   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      RUN   = 2'b00,
      DRAIN = 2'b01,
      LOAD  = 2'b10
   } arb_state_t;

   localparam int PORT_IF   = 0;
   localparam int PORT_D    = 1;
   localparam int PORT_LD   = 2;
   localparam int NUM_PORTS = 3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
   parameter int           W   = 16,
   parameter logic [W-1:0] MAX = '1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   // count up until MAX, then stick there
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                   cnt <= '0;
      else if (clr)              cnt <= '0;
      else if (inc && cnt != MAX) cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch, the
// MEM-stage data port and a halted-core program loader. One access per
// cycle, combinational grant, read data returned exactly one cycle later.
module mem_port_arbiter #(
   parameter int ADDR_W       = mips_pkg::ADDR_W,
   parameter int DATA_W       = mips_pkg::DATA_W,
   parameter int STARVE_LIMIT = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   input  logic              ld_req,
   input  logic              ld_we,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_wdata,
   output logic              ld_gnt,
   output logic              ld_rvalid,
   output logic [DATA_W-1:0] ld_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy_load,
   output logic [15:0]       if_stall_cnt
);

   import mips_pkg::*;

   localparam int SW = $clog2(STARVE_LIMIT + 1);

   arb_state_t                        state, state_nxt;
   logic [SW-1:0]                     starve_cnt;
   logic                              core_ok;
   logic                              if_first;
   logic [NUM_PORTS-1:0]              ret_tag;
   logic [NUM_PORTS-1:0][DATA_W-1:0]  rdata_q;

   // IF jumps ahead of data only once it has been passed over enough times
   assign if_first = if_req && (starve_cnt == SW'(STARVE_LIMIT));

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= RUN;
      else     state <= state_nxt;
   end

   // next state and grants; grants are forced low while reset is asserted
   always_comb begin
      state_nxt = state;
      core_ok   = 1'b0;
      if_gnt    = 1'b0;
      d_gnt     = 1'b0;
      ld_gnt    = 1'b0;
      case (state)
         RUN: begin
            if (ld_req) state_nxt = DRAIN;
            else        core_ok   = 1'b1;
         end
         DRAIN: state_nxt = LOAD;
         LOAD: begin
            if (ld_req) ld_gnt = 1'b1;
            else begin
               state_nxt = RUN;
               core_ok   = 1'b1;
            end
         end
         default: state_nxt = RUN;
      endcase
      if (core_ok) begin
         if (d_req && !if_first) d_gnt  = 1'b1;
         else if (if_req)        if_gnt = 1'b1;
      end
      if (rst) begin
         if_gnt = 1'b0;
         d_gnt  = 1'b0;
         ld_gnt = 1'b0;
      end
   end

   // memory command from whichever port won this cycle
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (ld_gnt) begin
         mem_en    = 1'b1;
         mem_we    = ld_we;
         mem_addr  = ld_addr;
         mem_wdata = ld_wdata;
      end else if (d_gnt) begin
         mem_en    = 1'b1;
         mem_we    = d_we;
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
      end else if (if_gnt) begin
         mem_en    = 1'b1;
         mem_addr  = if_addr;
      end
   end

   // one-hot return tag: which port (if any) owns next cycle's mem_rdata
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ret_tag <= '0;
      else begin
         ret_tag[PORT_IF] <= if_gnt;
         ret_tag[PORT_D]  <= d_gnt  && !d_we;
         ret_tag[PORT_LD] <= ld_gnt && !ld_we;
      end
   end

   // last delivered word per port, so idle rdata outputs hold steady
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rdata_q <= '0;
      else begin
         for (int p = 0; p < NUM_PORTS; p++)
            if (ret_tag[p]) rdata_q[p] <= mem_rdata;
      end
   end

   assign if_rvalid = ret_tag[PORT_IF];
   assign d_rvalid  = ret_tag[PORT_D];
   assign ld_rvalid = ret_tag[PORT_LD];
   assign if_rdata  = ret_tag[PORT_IF] ? mem_rdata : rdata_q[PORT_IF];
   assign d_rdata   = ret_tag[PORT_D]  ? mem_rdata : rdata_q[PORT_D];
   assign ld_rdata  = ret_tag[PORT_LD] ? mem_rdata : rdata_q[PORT_LD];

   assign busy_load = (state == DRAIN) || (state == LOAD);

   sat_counter #(.W(SW), .MAX(SW'(STARVE_LIMIT))) u_starve (
      .clk (clk),
      .rst (rst),
      .inc (state == RUN && if_req && !if_gnt),
      .clr (if_gnt),
      .cnt (starve_cnt)
   );

   sat_counter #(.W(16)) u_stall (
      .clk (clk),
      .rst (rst),
      .inc (if_req && !if_gnt),
      .clr (1'b0),
      .cnt (if_stall_cnt)
   );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus random bench for mem_port_arbiter with a RAM model and a
// transaction-level reference of who should win each cycle.
module tb_mem_port_arbiter;

   localparam int LIMIT = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [9:0]  if_addr;
   logic        if_gnt, if_rvalid;
   logic [31:0] if_rdata;
   logic        d_req, d_we;
   logic [9:0]  d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt, d_rvalid;
   logic [31:0] d_rdata;
   logic        ld_req, ld_we;
   logic [9:0]  ld_addr;
   logic [31:0] ld_wdata;
   logic        ld_gnt, ld_rvalid;
   logic [31:0] ld_rdata;
   logic        mem_en, mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        busy_load;
   logic [15:0] if_stall_cnt;

   mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
      .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .busy_load(busy_load), .if_stall_cnt(if_stall_cnt)
   );

   always #5 clk = ~clk;

   // RAM macro model: filled with a known pattern on the first edge
   logic [31:0] ram [1024];
   logic        ram_init = 1'b1;
   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < 1024; i++) ram[i] <= 32'(i) * 32'h9E3779B1 + 32'h1234;
         ram_init <= 1'b0;
      end else if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata     <= ram[mem_addr];
      end
   end

   // reference model state
   int          n_cmp = 0, n_fail = 0;
   logic [31:0] ref_mem [1024];
   int          mode;        // 0 core owns memory, 1 drain gap, 2 loader owns
   int          starve, stall;
   int          pend;        // port expecting data this cycle, -1 none
   logic [31:0] pend_data;
   logic [31:0] last [3];
   int          win;         // winner of the most recent cycle, -1 none

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mode = 0; starve = 0; stall = 0; pend = -1; pend_data = '0; win = -1;
      for (int p = 0; p < 3; p++) last[p] = '0;
   endtask

   // one clock: predict, check at negedge, advance model at posedge
   task automatic cycle();
      int          w, nmode;
      bit          core;
      logic [9:0]  a;
      logic        we;
      logic [31:0] wd;
      w = -1; nmode = mode; core = 0; a = '0; we = 0; wd = '0;
      case (mode)
         0: if (ld_req) nmode = 1; else core = 1;
         1: nmode = 2;
         default: if (ld_req) w = 2; else begin nmode = 0; core = 1; end
      endcase
      if (core) begin
         if (d_req && !(if_req && starve == LIMIT)) w = 1;
         else if (if_req) w = 0;
      end
      if (w == 0) a = if_addr;
      if (w == 1) begin a = d_addr;  we = d_we;  wd = d_wdata;  end
      if (w == 2) begin a = ld_addr; we = ld_we; wd = ld_wdata; end
      @(negedge clk);
      chk("if_gnt", 32'(if_gnt), 32'(w == 0));
      chk("d_gnt",  32'(d_gnt),  32'(w == 1));
      chk("ld_gnt", 32'(ld_gnt), 32'(w == 2));
      chk("mem_en", 32'(mem_en), 32'(w >= 0));
      if (w >= 0) begin
         chk("mem_addr", 32'(mem_addr), 32'(a));
         chk("mem_we",   32'(mem_we),   32'(we));
         if (we) chk("mem_wdata", mem_wdata, wd);
      end
      chk("if_rvalid", 32'(if_rvalid), 32'(pend == 0));
      chk("d_rvalid",  32'(d_rvalid),  32'(pend == 1));
      chk("ld_rvalid", 32'(ld_rvalid), 32'(pend == 2));
      chk("if_rdata",  if_rdata, (pend == 0) ? pend_data : last[0]);
      chk("d_rdata",   d_rdata,  (pend == 1) ? pend_data : last[1]);
      chk("ld_rdata",  ld_rdata, (pend == 2) ? pend_data : last[2]);
      chk("busy_load", 32'(busy_load), 32'(mode != 0));
      chk("if_stall_cnt", 32'(if_stall_cnt), 32'(stall));
      @(posedge clk);
      if (pend >= 0) last[pend] = pend_data;
      pend = -1;
      if (w >= 0) begin
         if (we) ref_mem[a] = wd;
         else begin pend = w; pend_data = ref_mem[a]; end
      end
      if (if_req && w != 0 && stall < 65535) stall++;
      if (w == 0) starve = 0;
      else if (mode == 0 && if_req && starve < LIMIT) starve++;
      mode = nmode;
      win  = w;
      #1;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) ref_mem[i] = 32'(i) * 32'h9E3779B1 + 32'h1234;
      rst = 1'b1;
      if_req = 0; if_addr = '0;
      d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
      ld_req = 0; ld_we = 0; ld_addr = '0; ld_wdata = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      // requests during reset must not be granted
      if_req = 1; d_req = 1; #1;
      chk("rst_if_gnt", 32'(if_gnt), 0);
      chk("rst_d_gnt",  32'(d_gnt),  0);
      chk("rst_mem_en", 32'(mem_en), 0);
      chk("rst_stall",  32'(if_stall_cnt), 0);
      chk("rst_rdata",  if_rdata | d_rdata | ld_rdata, 0);
      if_req = 0; d_req = 0;
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      // single fetch from address 5
      if_req = 1; if_addr = 10'd5; #1;
      chk("t1_if_gnt", 32'(if_gnt), 1);
      chk("t1_mem_addr", 32'(mem_addr), 5);
      cycle();
      if_req = 0;
      cycle();
      chk("t1_if_rdata", if_rdata, ref_mem[5]);
      chk("t1_stall", 32'(if_stall_cnt), 0);

      // store 0xCAFE to 10 then load it back
      d_req = 1; d_we = 1; d_addr = 10'd10; d_wdata = 32'hCAFE;
      cycle();
      d_we = 0;
      cycle();
      d_req = 0;
      #1; chk("t2_d_rvalid", 32'(d_rvalid), 1);
      chk("t2_d_rdata", d_rdata, 32'hCAFE);
      cycle();

      // contention: D,D,D,IF repeating
      if_req = 1; if_addr = 10'd20; d_req = 1; d_we = 0; d_addr = 10'd30;
      for (int k = 1; k <= 8; k++) begin
         cycle();
         chk("t3_pattern_d", 32'(win), (k % 4 == 0) ? 0 : 1);
         if (k == 4) chk("t3_stall_after4", 32'(if_stall_cnt), 3);
      end
      d_req = 0;

      // loader entry right after a granted fetch, then exit
      if_addr = 10'd7;
      cycle();
      chk("t4_if_granted", 32'(win), 0);
      ld_req = 1; ld_we = 0; ld_addr = 10'd10;
      #1; chk("t4_if_rv", 32'(if_rvalid), 1);
      chk("t4_no_if_gnt", 32'(if_gnt), 0);
      cycle();
      #1; chk("t4_drain_busy", 32'(busy_load), 1);
      chk("t4_drain_ld_gnt", 32'(ld_gnt), 0);
      cycle();
      #1; chk("t4_ld_gnt", 32'(ld_gnt), 1);
      cycle();
      ld_we = 1; ld_addr = 10'd40; ld_wdata = 32'h1234_5678;
      cycle();
      ld_req = 0;
      #1; chk("t4_exit_if_gnt", 32'(if_gnt), 1);
      cycle();
      if_req = 0;
      cycle();

      // async reset with a load outstanding
      d_req = 1; d_we = 0; d_addr = 10'd40;
      cycle();
      chk("t5_load_granted", 32'(win), 1);
      rst = 1'b1; d_req = 0; #1;
      chk("t5_rst_d_rvalid", 32'(d_rvalid), 0);
      chk("t5_rst_mem_en", 32'(mem_en), 0);
      chk("t5_rst_stall", 32'(if_stall_cnt), 0);
      chk("t5_rst_d_rdata", d_rdata, 0);
      model_reset();
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      cycle();
      cycle();

      // random traffic obeying the hold-until-granted handshake
      for (int n = 0; n < 3000; n++) begin
         cycle();
         if (win == 0 || !if_req) begin
            if_req = 1'($urandom_range(0, 1)); if_addr = 10'($urandom_range(0, 15));
         end
         if (win == 1 || !d_req) begin
            d_req = 1'($urandom_range(0, 1)); d_we = 1'($urandom_range(0, 1));
            d_addr = 10'($urandom_range(0, 15)); d_wdata = $urandom;
         end
         if (!ld_req) ld_req = ($urandom_range(0, 49) == 0);
         else if (win == 2) ld_req = ($urandom_range(0, 3) != 0);
         if (win == 2 || (mode == 0 && ld_req)) begin
            ld_we = 1'($urandom_range(0, 1)); ld_addr = 10'($urandom_range(0, 15));
            ld_wdata = $urandom;
         end
      end
      if_req = 0; d_req = 0; ld_req = 0;
      repeat (3) cycle();

      // stall counter saturation while the loader holds the port
      ld_req = 1; ld_we = 0; ld_addr = 10'd1; if_req = 1;
      for (int n = 0; n < 70000; n++) cycle();
      chk("t6_stall_sat", 32'(if_stall_cnt), 32'hFFFF);
      ld_req = 0; if_req = 0;
      repeat (2) cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
